// File: rtl/mem_copy_pkg.sv
// rtl/mem_copy_pkg.sv - shared types and default widths for the block copy engine
package mem_copy_pkg;

  localparam int DEFAULT_DW = 8;
  localparam int DEFAULT_AW = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } copy_state_t;

endpackage

// File: rtl/mem_copy_engine.sv
// rtl/mem_copy_engine.sv - byte-at-a-time memory copy master (read cycle, then write cycle)
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int DW = DEFAULT_DW,
  parameter int AW = DEFAULT_AW
) (
  input  logic          CLK,
  input  logic          ResetN,
  input  logic          Start,
  input  logic          Abort,
  input  logic [AW-1:0] SrcAddr,
  input  logic [AW-1:0] DstAddr,
  input  logic [AW-1:0] Length,
  output logic          Busy,
  output logic          Done,
  output logic [AW-1:0] DataAddress,
  output logic          ReadMem,
  output logic          WriteMem,
  output logic [DW-1:0] MemWrData,
  input  logic [DW-1:0] MemRdData
);

  copy_state_t   state_q, state_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] hold_q, hold_d;

  always_ff @(posedge CLK) begin
    if (!ResetN) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          src_d   = SrcAddr;
          dst_d   = DstAddr;
          cnt_d   = Length;
          state_d = (Length != '0) ? READ : DONE;
        end
      end
      READ: begin
        hold_d  = MemRdData;
        src_d   = src_q + AW'(1);
        state_d = Abort ? IDLE : WRITE;
      end
      WRITE: begin
        // The byte driven this cycle is committed even when aborting.
        dst_d = dst_q + AW'(1);
        cnt_d = cnt_q - AW'(1);
        if (Abort)
          state_d = IDLE;
        else if (cnt_q == AW'(1))
          state_d = DONE;
        else
          state_d = READ;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Moore outputs: only state and registers feed the memory port.
  always_comb begin
    Busy        = 1'b0;
    Done        = 1'b0;
    ReadMem     = 1'b0;
    WriteMem    = 1'b0;
    DataAddress = '0;
    MemWrData   = '0;
    unique case (state_q)
      READ: begin
        Busy        = 1'b1;
        ReadMem     = 1'b1;
        DataAddress = src_q;
      end
      WRITE: begin
        Busy        = 1'b1;
        WriteMem    = 1'b1;
        DataAddress = dst_q;
        MemWrData   = hold_q;
      end
      DONE: begin
        Done = 1'b1;
      end
      default: begin
        Busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb/tb_mem_copy_engine.sv - directed self-checking bench for mem_copy_engine
module tb_mem_copy_engine;

  logic       CLK = 1'b0;
  logic       ResetN = 1'b0;
  logic       Start = 1'b0;
  logic       Abort = 1'b0;
  logic [7:0] SrcAddr = '0;
  logic [7:0] DstAddr = '0;
  logic [7:0] Length = '0;
  logic       Busy, Done, ReadMem, WriteMem;
  logic [7:0] DataAddress, MemWrData, MemRdData;

  logic [7:0] mem [256];
  logic       pk_en = 1'b0;
  logic [7:0] pk_a = '0;
  logic [7:0] pk_d = '0;

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         t_cyc = 0;
  int         done_rel = 0;
  int         done_n = 0;
  int         busy_n = 0;
  int         both_n = 0;
  logic [7:0] rd_q[$];
  logic [7:0] wr_q[$];

  mem_copy_engine #(.DW(8), .AW(8)) dut (
    .CLK(CLK), .ResetN(ResetN), .Start(Start), .Abort(Abort),
    .SrcAddr(SrcAddr), .DstAddr(DstAddr), .Length(Length),
    .Busy(Busy), .Done(Done), .DataAddress(DataAddress),
    .ReadMem(ReadMem), .WriteMem(WriteMem),
    .MemWrData(MemWrData), .MemRdData(MemRdData)
  );

  always #5 CLK = ~CLK;

  assign MemRdData = mem[DataAddress];

  always @(posedge CLK) begin
    if (pk_en)
      mem[pk_a] <= pk_d;
    else if (WriteMem)
      mem[DataAddress] <= MemWrData;
  end

  always @(negedge CLK) begin
    cyc <= cyc + 1;
    if (Busy) busy_n <= busy_n + 1;
    if (Done) begin
      done_n   <= done_n + 1;
      done_rel <= cyc + 1 - t_cyc;
    end
    if (ReadMem && WriteMem) both_n <= both_n + 1;
    if (ReadMem) rd_q.push_back(DataAddress);
    if (WriteMem) wr_q.push_back(DataAddress);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(negedge CLK);
    pk_en = 1'b1; pk_a = a; pk_d = d;
    @(posedge CLK);
    #1 pk_en = 1'b0;
  endtask

  // Returns #1 after the accepting edge, i.e. inside cycle t+1.
  task automatic start_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l);
    @(negedge CLK);
    Start = 1'b1; SrcAddr = s; DstAddr = d; Length = l;
    @(posedge CLK);
    t_cyc = cyc; done_rel = 0; done_n = 0; busy_n = 0; both_n = 0;
    rd_q.delete(); wr_q.delete();
    #1 Start = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge CLK);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, 32'(Busy), 0);
    chk({tag, "_done"}, 32'(Done), 0);
    chk({tag, "_rd"}, 32'(ReadMem), 0);
    chk({tag, "_wr"}, 32'(WriteMem), 0);
    chk({tag, "_addr"}, 32'(DataAddress), 0);
    chk({tag, "_wdata"}, 32'(MemWrData), 0);
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #1 ResetN = 1'b1;
    @(negedge CLK); #1;
    chk_idle_outputs("reset");

    poke(8'h10, 8'hA1); poke(8'h11, 8'hB2); poke(8'h12, 8'hC3); poke(8'h13, 8'hD4);
    start_copy(8'h10, 8'h80, 8'd4);
    settle(14);
    chk("t1_done_cycle", 32'(done_rel), 9);
    chk("t1_done_pulses", 32'(done_n), 1);
    chk("t1_busy_cycles", 32'(busy_n), 8);
    chk("t1_rd_wr_overlap", 32'(both_n), 0);
    chk("t1_m80", 32'(mem[8'h80]), 32'hA1);
    chk("t1_m81", 32'(mem[8'h81]), 32'hB2);
    chk("t1_m82", 32'(mem[8'h82]), 32'hC3);
    chk("t1_m83", 32'(mem[8'h83]), 32'hD4);
    chk("t1_idle_busy", 32'(Busy), 0);

    poke(8'h20, 8'h77);
    start_copy(8'h10, 8'h20, 8'd0);
    settle(5);
    chk("t2_done_cycle", 32'(done_rel), 1);
    chk("t2_done_pulses", 32'(done_n), 1);
    chk("t2_reads", 32'(rd_q.size()), 0);
    chk("t2_writes", 32'(wr_q.size()), 0);
    chk("t2_m20", 32'(mem[8'h20]), 32'h77);

    poke(8'hFE, 8'h11); poke(8'hFF, 8'h22); poke(8'h00, 8'h33);
    start_copy(8'hFE, 8'h40, 8'd3);
    settle(10);
    chk("t3_done_cycle", 32'(done_rel), 7);
    chk("t3_nreads", 32'(rd_q.size()), 3);
    chk("t3_nwrites", 32'(wr_q.size()), 3);
    if (rd_q.size() == 3 && wr_q.size() == 3) begin
      chk("t3_rd0", 32'(rd_q[0]), 32'hFE);
      chk("t3_rd1", 32'(rd_q[1]), 32'hFF);
      chk("t3_rd2", 32'(rd_q[2]), 32'h00);
      chk("t3_wr0", 32'(wr_q[0]), 32'h40);
      chk("t3_wr2", 32'(wr_q[2]), 32'h42);
    end
    chk("t3_m40", 32'(mem[8'h40]), 32'h11);
    chk("t3_m41", 32'(mem[8'h41]), 32'h22);
    chk("t3_m42", 32'(mem[8'h42]), 32'h33);

    poke(8'h92, 8'h00);
    start_copy(8'h10, 8'h90, 8'd5);
    repeat (3) @(posedge CLK);
    #1 Abort = 1'b1;
    @(posedge CLK);
    #1 Abort = 1'b0;
    @(negedge CLK); #1;
    chk("t4_idle_next_busy", 32'(Busy), 0);
    settle(12);
    chk("t4_writes", 32'(wr_q.size()), 2);
    chk("t4_done_pulses", 32'(done_n), 0);
    chk("t4_busy_cycles", 32'(busy_n), 4);
    chk("t4_m90", 32'(mem[8'h90]), 32'hA1);
    chk("t4_m91", 32'(mem[8'h91]), 32'hB2);
    chk("t4_m92", 32'(mem[8'h92]), 32'h00);

    start_copy(8'h10, 8'hA0, 8'd4);
    repeat (2) @(posedge CLK);
    #1 ResetN = 1'b0;
    @(posedge CLK);
    #1 ResetN = 1'b1;
    @(negedge CLK); #1;
    chk_idle_outputs("t5_after_reset");
    settle(10);
    chk("t5_reads", 32'(rd_q.size()), 2);
    chk("t5_writes", 32'(wr_q.size()), 1);
    chk("t5_done_pulses", 32'(done_n), 0);
    start_copy(8'h00, 8'h50, 8'd1);
    settle(6);
    chk("t5b_done_cycle", 32'(done_rel), 3);
    chk("t5b_m50", 32'(mem[8'h50]), 32'h33);

    poke(8'h10, 8'h55); poke(8'hF0, 8'h00);
    start_copy(8'h10, 8'h11, 8'd3);
    Start = 1'b1; SrcAddr = 8'h00; DstAddr = 8'hF0; Length = 8'd7;
    @(posedge CLK);
    #1 Start = 1'b0;
    settle(10);
    chk("t6_done_cycle", 32'(done_rel), 7);
    chk("t6_busy_cycles", 32'(busy_n), 6);
    chk("t6_writes", 32'(wr_q.size()), 3);
    chk("t6_m11", 32'(mem[8'h11]), 32'h55);
    chk("t6_m12", 32'(mem[8'h12]), 32'h55);
    chk("t6_m13", 32'(mem[8'h13]), 32'h55);
    chk("t6_mF0", 32'(mem[8'hF0]), 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_copy_engine.md
# mem_copy_engine

Bus-master block copy engine that drives the data memory's single port (address, read enable, write enable, write data) and consumes its combinational read data. Given a source address, destination address and byte count, it copies bytes one at a time: one read cycle, then one write cycle per byte. It sits beside the processor core as an alternate master of the data memory port. The core must not drive that port while `Busy` is high.

## Interface
Parameters:
- `DW`, 8: data width, matches the memory word.
- `AW`, 8: address width; the 256-entry space wraps mod 2^AW.

Ports:
- `CLK`  in  1  — clock; all state updates on posedge.
- `ResetN`  in  1  — synchronous, active-low reset.
- `Start`  in  1  — request a copy; sampled only in IDLE.
- `Abort`  in  1  — terminate the current copy.
- `SrcAddr`  in  AW  — first source address; captured on an accepted Start.
- `DstAddr`  in  AW  — first destination address; captured on an accepted Start.
- `Length`  in  AW  — byte count; captured on an accepted Start; 0 means no-op.
- `Busy`  out  1  — high in READ and WRITE.
- `Done`  out  1  — one-cycle pulse when a copy completes normally.
- `DataAddress`  out  AW  — memory address.
- `ReadMem`  out  1  — memory read enable.
- `WriteMem`  out  1  — memory write enable.
- `MemWrData`  out  DW  — data to memory (memory `DataIn`).
- `MemRdData`  in  DW  — data from memory (memory `DataOut`); valid combinationally while `ReadMem`=1.

## Operation
- States: IDLE, READ, WRITE, DONE.
- Reset (`ResetN`=0 at posedge):
  - State returns to IDLE.
  - Internal registers (source pointer, destination pointer, remaining count, holding register) are cleared to 0.
  - Outputs: `Busy`=0, `Done`=0, `ReadMem`=0, `WriteMem`=0, `DataAddress`=0, `MemWrData`=0.
  - This applies mid-copy; no further memory access occurs.
- IDLE:
  - All outputs are 0.
  - If `Start`=1, capture `SrcAddr`, `DstAddr` and `Length`.
  - Length≠0 → READ. Length=0 → DONE.
- READ:
  - Drive `ReadMem`=1, `DataAddress`=source pointer.
  - At the edge, latch `MemRdData` into the holding register, increment the source pointer (wraps 0xFF→0x00), then → WRITE.
- WRITE:
  - Drive `WriteMem`=1, `DataAddress`=destination pointer, `MemWrData`=holding register.
  - At the edge, increment the destination pointer (wraps) and decrement the remaining count.
  - Remaining count was 1 → DONE; otherwise → READ.
- DONE:
  - Drive `Done`=1 for exactly one cycle with no memory access, then → IDLE.
- Outputs are Moore: decoded from state and registers only, never combinationally from `Start` or `Abort`.
- Abort:
  - Sampled at each edge in READ or WRITE; forces the next state to IDLE with no `Done`.
  - Memory access already driven in that cycle completes, so a WRITE-cycle abort still commits that byte.
  - Abort has priority over the normal transition. It is ignored in IDLE and DONE.
- `Start` in any state other than IDLE is ignored; inputs are not re-captured.
- Simultaneous `Start` and `Abort` in IDLE: Start is accepted.
- Overlap: copy is strictly ascending (forward). When the destination lies within (src, src+Length), bytes already written are re-read. The resulting replication is defined behaviour, not an error.
- Address wrap: pointers are AW-bit and wrap silently. The remaining count never wraps; there is no 256-byte mode.

## Timing
- Start accepted at edge t:
  - Byte k READ occupies cycle t+1+2k; its WRITE occupies t+2+2k.
  - `Done` is high in cycle t+2L+1; IDLE from t+2L+2.
  - Total latency from Start to Done: 2L+1 cycles.
- Length=0: `Done` is high in cycle t+1.
- `Busy` is high exactly during the 2L READ/WRITE cycles.
- Back-to-back: a new Start is accepted at the edge ending the first IDLE cycle after DONE.
- `ReadMem` and `WriteMem` are never high in the same cycle.

## Structure
- Package `mem_copy_pkg`:
  - State enum type `copy_state_t` (IDLE, READ, WRITE, DONE).
  - Default widths `DW`/`AW` as localparams.
- No sub-module: a single state machine plus datapath (two pointers, count, holding register).

## Test plan
- Preload M[0x10..0x13]=0xA1,0xB2,0xC3,0xD4; Start Src=0x10 Dst=0x80 Len=4 → M[0x80..0x83] match the source; Done in cycle t+9; Busy high exactly 8 cycles.
- Len=0, Src=0x10, Dst=0x20 → Done in cycle t+1; ReadMem and WriteMem never asserted; memory unchanged.
- Src=0xFE Dst=0x40 Len=3 → reads 0xFE, 0xFF, 0x00 in order; writes to 0x40–0x42.
- Len=5 copy; Abort high during the second WRITE cycle → exactly 2 bytes written; Done never pulses; IDLE next cycle.
- ResetN low mid-copy (during a READ) → next cycle all outputs 0; no further memory access; a subsequent Start Src=0x00 Dst=0x50 Len=1 completes normally.
- Overlap Src=0x10 Dst=0x11 Len=3, M[0x10]=0x55 → M[0x11..0x13] all 0x55; Start pulsed while Busy is ignored.
